// File: rtl/ddr4_read_training_sweep_ctrl.sv
// Read-training sweep engine for one DQ lane delay line: sweeps taps upward,
// scores each tap from the eye-monitor early/late flags, keeps the first passing
// window of at least MIN_WINDOW taps, then walks the delay line back to its centre.
// Ports:
//   FAB_CLK, ARST                      clock, asynchronous active-high reset
//   START                              1-cycle request, accepted only when idle
//   EYE_MONITOR_EARLY/LATE             per-cycle eye-monitor flags for the current tap
//   DELAY_LINE_OUT_OF_RANGE            delay line reports it is at a limit
//   DELAY_LINE_LOAD/MOVE/DIRECTION     delay line control (registered pulses)
//   EYE_MONITOR_CLEAR_FLAGS            1-cycle clear of the eye-monitor flags
//   TRAIN_BUSY/DONE/ERR                training status (DONE/ERR are held levels)
//   TAP_CENTER, WINDOW_WIDTH           result, valid with TRAIN_DONE
module ddr4_read_training_sweep_ctrl #(
   parameter int TAP_W         = 8,
   parameter int MAX_TAP       = 255,
   parameter int SETTLE_CYCLES = 8,
   parameter int SAMPLE_CYCLES = 16,
   parameter int MIN_WINDOW    = 4
) (
   input  logic             FAB_CLK,
   input  logic             ARST,
   input  logic             START,
   input  logic             EYE_MONITOR_EARLY,
   input  logic             EYE_MONITOR_LATE,
   input  logic             DELAY_LINE_OUT_OF_RANGE,
   output logic             DELAY_LINE_LOAD,
   output logic             DELAY_LINE_MOVE,
   output logic             DELAY_LINE_DIRECTION,
   output logic             EYE_MONITOR_CLEAR_FLAGS,
   output logic             TRAIN_BUSY,
   output logic             TRAIN_DONE,
   output logic             TRAIN_ERR,
   output logic [TAP_W-1:0] TAP_CENTER,
   output logic [TAP_W:0]   WINDOW_WIDTH
);

   localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
   localparam logic [TAP_W-1:0] TAP_LAST    = TAP_W'(MAX_TAP);
   localparam logic [TAP_W:0]   MIN_W       = (TAP_W + 1)'(MIN_WINDOW);

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_CLEAR, S_SETTLE, S_SAMPLE, S_EVAL,
      S_STEP, S_GAP, S_CENTER, S_MOVE_DN, S_DONE, S_ERROR
   } state_t;

   state_t           state_q;
   logic [TAP_W-1:0] tap_q;
   logic [TAP_W-1:0] first_q;
   logic [TAP_W-1:0] last_q;
   logic             in_win_q;
   logic             fail_q;
   logic [CNT_W-1:0] cnt_q;
   logic [TAP_W-1:0] centre_q;
   logic             dn_phase_q;   // 0: may issue a down-move, 1: idle cycle after it
   logic             dn_moved_q;   // at least one down-move has landed
   logic             load_q;
   logic             move_q;
   logic             dir_q;
   logic             clear_q;
   logic             busy_q;
   logic             done_q;
   logic             err_q;
   logic [TAP_W-1:0] tap_center_q;
   logic [TAP_W:0]   width_q;

   // Window arithmetic done one bit wider so first+last cannot overflow.
   logic [TAP_W:0]   win_width;
   logic [TAP_W:0]   centre_sum;
   logic             win_ok;

   always_comb begin
      win_width  = {1'b0, last_q} - {1'b0, first_q} + (TAP_W + 1)'(1);
      centre_sum = {1'b0, first_q} + {1'b0, last_q};
      win_ok     = in_win_q && (win_width >= MIN_W);
   end

   always_ff @(posedge FAB_CLK or posedge ARST) begin
      if (ARST) begin
         state_q      <= S_IDLE;
         tap_q        <= '0;
         first_q      <= '0;
         last_q       <= '0;
         in_win_q     <= 1'b0;
         fail_q       <= 1'b0;
         cnt_q        <= '0;
         centre_q     <= '0;
         dn_phase_q   <= 1'b0;
         dn_moved_q   <= 1'b0;
         load_q       <= 1'b0;
         move_q       <= 1'b0;
         dir_q        <= 1'b0;
         clear_q      <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         tap_center_q <= '0;
         width_q      <= '0;
      end else begin
         // Strobes are single-cycle unless re-armed below.
         load_q  <= 1'b0;
         move_q  <= 1'b0;
         clear_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (START) begin
                  load_q  <= 1'b1;   // LOAD pulse coincides with the LOAD state
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  err_q   <= 1'b0;
                  state_q <= S_LOAD;
               end
            end
            S_LOAD: begin
               tap_q    <= '0;
               in_win_q <= 1'b0;
               dir_q    <= 1'b1;     // set while no move is in flight
               state_q  <= S_CLEAR;
            end
            S_CLEAR: begin
               // Clear strobe lands one cycle later, so the CLEAR state itself
               // is the idle gap separating it from the preceding LOAD/MOVE.
               clear_q <= 1'b1;
               cnt_q   <= '0;
               state_q <= S_SETTLE;
            end
            S_SETTLE: begin
               if (cnt_q == SETTLE_LAST) begin
                  cnt_q   <= '0;
                  fail_q  <= 1'b0;
                  state_q <= S_SAMPLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_SAMPLE: begin
               fail_q <= fail_q | EYE_MONITOR_EARLY | EYE_MONITOR_LATE;
               if (cnt_q == SAMPLE_LAST) begin
                  state_q <= S_EVAL;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_EVAL: begin
               if (!fail_q) begin
                  if (!in_win_q) begin
                     first_q  <= tap_q;
                     in_win_q <= 1'b1;
                  end
                  last_q  <= tap_q;
                  state_q <= S_STEP;
               end else if (win_ok) begin
                  state_q <= S_CENTER;
               end else begin
                  in_win_q <= 1'b0;  // too narrow (or no window): discard
                  state_q  <= S_STEP;
               end
            end
            S_STEP: begin
               if ((tap_q == TAP_LAST) || DELAY_LINE_OUT_OF_RANGE) begin
                  state_q <= win_ok ? S_CENTER : S_ERROR;
               end else begin
                  move_q  <= 1'b1;
                  tap_q   <= tap_q + 1'b1;
                  state_q <= S_GAP;
               end
            end
            S_GAP: begin
               state_q <= S_CLEAR;
            end
            S_CENTER: begin
               centre_q   <= TAP_W'(centre_sum >> 1);
               width_q    <= win_width;
               dir_q      <= 1'b0;
               dn_phase_q <= 1'b0;
               dn_moved_q <= 1'b0;
               state_q    <= S_MOVE_DN;
            end
            S_MOVE_DN: begin
               if (!dn_phase_q) begin
                  // Out-of-range is judged only once a down-move has landed:
                  // the sweep may legitimately have stopped at the upper limit.
                  if (dn_moved_q && DELAY_LINE_OUT_OF_RANGE) begin
                     state_q <= S_ERROR;
                  end else if (tap_q == centre_q) begin
                     state_q <= S_DONE;
                  end else begin
                     move_q     <= 1'b1;
                     tap_q      <= tap_q - 1'b1;
                     dn_phase_q <= 1'b1;
                     dn_moved_q <= 1'b1;
                  end
               end else begin
                  dn_phase_q <= 1'b0;
               end
            end
            S_DONE: begin
               tap_center_q <= tap_q;
               done_q       <= 1'b1;
               busy_q       <= 1'b0;
               state_q      <= S_IDLE;
            end
            S_ERROR: begin
               err_q        <= 1'b1;
               busy_q       <= 1'b0;
               tap_center_q <= '0;
               width_q      <= '0;
               state_q      <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign DELAY_LINE_LOAD         = load_q;
   assign DELAY_LINE_MOVE         = move_q;
   assign DELAY_LINE_DIRECTION    = dir_q;
   assign EYE_MONITOR_CLEAR_FLAGS = clear_q;
   assign TRAIN_BUSY              = busy_q;
   assign TRAIN_DONE              = done_q;
   assign TRAIN_ERR               = err_q;
   assign TAP_CENTER              = tap_center_q;
   assign WINDOW_WIDTH            = width_q;

endmodule

// File: tb/tb_ddr4_read_training_sweep_ctrl.sv
module tb_ddr4_read_training_sweep_ctrl;

   localparam int TAP_W  = 8;
   localparam int MAXT   = 31;
   localparam int SETTLE = 2;
   localparam int SAMPLE = 4;
   localparam int MINW   = 4;

   logic FAB_CLK = 1'b0;
   logic ARST    = 1'b1;
   logic START   = 1'b0;
   logic EYE_MONITOR_EARLY = 1'b0;
   logic EYE_MONITOR_LATE  = 1'b0;
   logic DELAY_LINE_OUT_OF_RANGE = 1'b0;
   logic load, move, dir, clr, busy, done, err;
   logic [TAP_W-1:0] tap_c;
   logic [TAP_W:0]   win_w;

   int checks   = 0;
   int failures = 0;

   // Lane model: delay line tap tracked from the DUT's pulses, eye given as a pass mask.
   logic [31:0] pmask   = '0;
   bit          oor_en  = 1'b0;
   int          oor_tap = 0;
   int dl_tap = 0, load_cnt = 0, up_cnt = 0, dn_cnt = 0, cyc = 0, last_dn = -1;
   logic prev_any = 1'b0, prev_move = 1'b0, prev_dir = 1'b0;

   ddr4_read_training_sweep_ctrl #(
      .TAP_W(TAP_W), .MAX_TAP(MAXT), .SETTLE_CYCLES(SETTLE),
      .SAMPLE_CYCLES(SAMPLE), .MIN_WINDOW(MINW)
   ) dut (
      .FAB_CLK(FAB_CLK),
      .ARST(ARST),
      .START(START),
      .EYE_MONITOR_EARLY(EYE_MONITOR_EARLY),
      .EYE_MONITOR_LATE(EYE_MONITOR_LATE),
      .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE),
      .DELAY_LINE_LOAD(load),
      .DELAY_LINE_MOVE(move),
      .DELAY_LINE_DIRECTION(dir),
      .EYE_MONITOR_CLEAR_FLAGS(clr),
      .TRAIN_BUSY(busy),
      .TRAIN_DONE(done),
      .TRAIN_ERR(err),
      .TAP_CENTER(tap_c),
      .WINDOW_WIDTH(win_w)
   );

   always #5 FAB_CLK = ~FAB_CLK;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] rng(input int a, input int b);
      logic [31:0] m;
      m = '0;
      for (int i = a; i <= b && i <= 31; i++) m[i] = 1'b1;
      return m;
   endfunction

   // Reference: walk the taps in order, track the first window reaching MINW.
   function automatic void model(input logic [31:0] pm, input bit oen, input int otap,
                                 output bit ok, output int cen, output int wid,
                                 output int up, output int dn);
      int  first, last, stop;
      bit  inw, found;
      first = 0; last = 0; inw = 0; found = 0; stop = MAXT;
      for (int t = 0; t <= MAXT; t++) begin
         if (pm[t]) begin
            if (!inw) begin first = t; inw = 1; end
            last = t;
         end else if (inw) begin
            if (last - first + 1 >= MINW) begin found = 1; stop = t; break; end
            inw = 0;
         end
         if (t == MAXT || (oen && t >= otap)) begin
            stop = t;
            if (inw && last - first + 1 >= MINW) found = 1;
            break;
         end
      end
      ok = found;
      up = stop;
      if (found) begin
         cen = (first + last) / 2;
         wid = last - first + 1;
         dn  = stop - cen;
      end else begin
         cen = 0; wid = 0; dn = 0;
      end
   endfunction

   // Per-cycle protocol checks, delay-line tracking and lane stimulus.
   always @(negedge FAB_CLK) begin
      int np;
      logic [1:0] r;
      cyc++;
      if (!ARST) begin
         np = int'(load) + int'(move) + int'(clr);
         chk("pulse_exclusive", (np <= 1), 1);
         chk("pulse_spacing", (np != 0 && prev_any), 0);
         chk("dir_stable", ((dir !== prev_dir) && (move || prev_move)), 0);
         if (load) begin dl_tap = 0; load_cnt++; end
         if (move) begin
            if (dir) begin
               dl_tap++; up_cnt++;
            end else begin
               dl_tap--; dn_cnt++;
               if (last_dn >= 0) chk("down_period", cyc - last_dn, 2);
               last_dn = cyc;
            end
         end
         chk("tap_range", (dl_tap >= 0 && dl_tap <= MAXT), 1);
      end
      prev_any  = load | move | clr;
      prev_move = move;
      prev_dir  = dir;
      if (dl_tap >= 0 && dl_tap <= MAXT && pmask[dl_tap]) begin
         EYE_MONITOR_EARLY = 1'b0;
         EYE_MONITOR_LATE  = 1'b0;
      end else begin
         r = 2'($urandom_range(1, 3));
         EYE_MONITOR_EARLY = r[1];
         EYE_MONITOR_LATE  = r[0];
      end
      DELAY_LINE_OUT_OF_RANGE = oor_en && (dl_tap >= oor_tap);
   end

   // Caller is always positioned 1 time unit after a falling edge.
   task automatic run_case(input string nm, input logic [31:0] pm, input bit oen, input int otap,
                           input bit spur, input bit pin, input int l_ok, input int l_cen,
                           input int l_wid, input int l_up, input int l_dn);
      bit ok;
      int cen, wid, up, dn, n;
      model(pm, oen, otap, ok, cen, wid, up, dn);
      if (pin) begin
         chk({nm, ".model_ok"},  ok,  l_ok);
         chk({nm, ".model_cen"}, cen, l_cen);
         chk({nm, ".model_wid"}, wid, l_wid);
         chk({nm, ".model_up"},  up,  l_up);
         chk({nm, ".model_dn"},  dn,  l_dn);
      end
      pmask = pm; oor_en = oen; oor_tap = otap;
      load_cnt = 0; up_cnt = 0; dn_cnt = 0; last_dn = -1;
      START = 1'b1;
      @(negedge FAB_CLK); #1;
      START = 1'b0;
      chk({nm, ".busy_start"}, busy, 1);
      n = 0;
      while (busy && n < 5000) begin
         @(negedge FAB_CLK); #1;
         n++;
         START = (spur && n == 40) ? 1'b1 : 1'b0;
      end
      START = 1'b0;
      chk({nm, ".finished"}, busy, 0);
      if (busy) begin
         ARST = 1'b1;
         @(negedge FAB_CLK); #1;
         ARST = 1'b0;
         return;
      end
      chk({nm, ".done"},   done,  ok);
      chk({nm, ".err"},    err,   !ok);
      chk({nm, ".center"}, tap_c, cen);
      chk({nm, ".width"},  win_w, wid);
      chk({nm, ".up_moves"}, up_cnt, up);
      chk({nm, ".dn_moves"}, dn_cnt, dn);
      chk({nm, ".loads"}, load_cnt, 1);
      if (ok) chk({nm, ".parked_tap"}, dl_tap, cen);
      repeat (3) begin @(negedge FAB_CLK); #1; end
      chk({nm, ".done_held"}, done, ok);
      chk({nm, ".err_held"},  err,  !ok);
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, ".load"},  load,  0);
      chk({nm, ".move"},  move,  0);
      chk({nm, ".dir"},   dir,   0);
      chk({nm, ".clear"}, clr,   0);
      chk({nm, ".busy"},  busy,  0);
      chk({nm, ".done"},  done,  0);
      chk({nm, ".err"},   err,   0);
      chk({nm, ".tapc"},  tap_c, 0);
      chk({nm, ".width"}, win_w, 0);
   endtask

   initial begin
      int n;
      ARST = 1'b1;
      repeat (2) @(negedge FAB_CLK);
      #1;
      chk_all_zero("reset");
      ARST = 1'b0;
      @(negedge FAB_CLK); #1;

      run_case("t1_eye10_20",   rng(10, 20), 0, 0, 0, 1, 1, 15, 11, 21, 6);
      run_case("t2_glitch",     rng(3, 4) | rng(12, 19), 0, 0, 0, 1, 1, 15, 8, 20, 5);
      run_case("t3_eye_at_max", rng(25, 31), 0, 0, 0, 1, 1, 28, 7, 31, 3);
      run_case("t4_no_eye",     32'h0, 0, 0, 0, 1, 0, 0, 0, 31, 0);
      run_case("t5_oor18",      rng(10, 25), 1, 18, 0, 1, 1, 14, 9, 18, 4);

      for (int k = 0; k < 14; k++) begin
         int a, b, g, gl, ot;
         logic [31:0] m;
         bit oe;
         a  = $urandom_range(0, 28);
         b  = $urandom_range(a, 31);
         m  = (k % 5 == 4) ? 32'h0 : rng(a, b);
         if ($urandom_range(0, 1) == 1) begin
            g  = $urandom_range(0, 29);
            gl = $urandom_range(0, 2);
            m  = m | rng(g, g + gl);
         end
         oe = ($urandom_range(0, 3) == 0);
         ot = $urandom_range(4, 31);
         run_case($sformatf("rand%0d", k), m, oe, ot, (k % 3 == 0), 0, 0, 0, 0, 0, 0);
      end

      // Reset in the middle of sampling tap 7, then restart.
      pmask = rng(5, 15); oor_en = 0; load_cnt = 0;
      START = 1'b1;
      @(negedge FAB_CLK); #1;
      START = 1'b0;
      n = 0;
      while (!(clr && dl_tap == 7) && n < 2000) begin
         @(negedge FAB_CLK); #1;
         n++;
      end
      chk("t6.reach_tap7", (clr && dl_tap == 7), 1);
      repeat (2) begin @(negedge FAB_CLK); #1; end
      #2 ARST = 1'b1;
      #1;
      chk_all_zero("t6.async");
      @(posedge FAB_CLK); #1;
      chk_all_zero("t6.edge");
      @(negedge FAB_CLK); #1;
      ARST = 1'b0;
      repeat (4) begin
         @(negedge FAB_CLK); #1;
         chk("t6.quiet_pulses", (load | move | clr), 0);
         chk("t6.quiet_busy", busy, 0);
      end
      run_case("t6_restart", rng(10, 20), 0, 0, 1, 1, 1, 15, 11, 21, 6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog simulation time limit reached actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

endmodule
